// File: rtl/cdda_feed_pkg.sv
// rtl/cdda_feed_pkg.sv - shared state type and default constants for the CD-DA sector feeder
package cdda_feed_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    STREAM,
    DONE
  } state_t;

  // 2352-byte Red Book sector carried as 16-bit words
  localparam int CDDA_SECTOR_WORDS   = 1176;
  // 100 ms of host silence at 28.375 MHz
  localparam int CDDA_TIMEOUT_CYCLES = 2837516;
  // covers the downstream 3-cycle WRITE_REQ update latency
  localparam int DONE_HOLD           = 4;

endpackage

// File: rtl/cdda_feed_watchdog.sv
// rtl/cdda_feed_watchdog.sv - host-silence cycle counter with single-cycle expiry
module cdda_feed_watchdog import cdda_feed_pkg::*; #(
  parameter int TIMEOUT_CYCLES = CDDA_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  // count enabled cycles; saturate at the limit so a stalled owner never sees a wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && cnt != LIMIT)
      cnt <= cnt + 1'b1;
  end

  assign expire = en & ~clr & (cnt == LIMIT);

endmodule

// File: rtl/cdda_feed.sv
// rtl/cdda_feed.sv - host sector fetcher feeding the CD-DA sample FIFO; CDDA_FEED_BYTESWAP_EN swaps host bytes
module cdda_feed import cdda_feed_pkg::*; #(
  parameter int SECTOR_WORDS   = CDDA_SECTOR_WORDS,
  parameter int TIMEOUT_CYCLES = CDDA_TIMEOUT_CYCLES
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        WRITE_REQ,
  output logic        WRITE,
  output logic [15:0] DOUT,
  output logic        SECTOR_REQ,
  input  logic        SECTOR_ACK,
  input  logic        HOST_VALID,
  input  logic [15:0] HOST_DATA,
  output logic        HOST_READY,
  output logic        TIMEOUT,
  output logic [15:0] SECTOR_COUNT
);

  localparam logic [10:0] LAST_WORD = 11'(SECTOR_WORDS);
  localparam logic [1:0]  HOLD_LAST = 2'(DONE_HOLD - 1);

  state_t      state;
  logic [10:0] word_cnt;
  logic [1:0]  hold_cnt;
  logic        pad_pending;
  logic        accept;
  logic        wd_en;
  logic        wd_clr;
  logic        wd_expire;
  logic [15:0] host_word;

`ifdef CDDA_FEED_BYTESWAP_EN
  assign host_word = {HOST_DATA[7:0], HOST_DATA[15:8]};
`else
  assign host_word = HOST_DATA;
`endif

  // one word per two cycles: never accept while the previous strobe is still out
  assign HOST_READY = (state == STREAM) & ~WRITE & ~pad_pending;
  assign accept     = HOST_VALID & HOST_READY;

  // the watchdog runs only while waiting on the host; outside that it is held clear
  assign wd_en  = ((state == REQ) | (state == STREAM)) & ~pad_pending;
  assign wd_clr = ~wd_en | accept | ((state == REQ) & SECTOR_ACK);

  cdda_feed_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (CLK),
    .rst    (RESET),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  // sector fetch sequencer with registered strobes and counters
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      word_cnt     <= '0;
      hold_cnt     <= '0;
      pad_pending  <= 1'b0;
      WRITE        <= 1'b0;
      DOUT         <= '0;
      SECTOR_REQ   <= 1'b0;
      TIMEOUT      <= 1'b0;
      SECTOR_COUNT <= '0;
    end else begin
      WRITE   <= 1'b0;
      TIMEOUT <= 1'b0;
      case (state)
        IDLE: begin
          if (ENABLE && WRITE_REQ) begin
            state      <= REQ;
            SECTOR_REQ <= 1'b1;
          end
        end
        REQ: begin
          if (SECTOR_ACK) begin
            state      <= STREAM;
            SECTOR_REQ <= 1'b0;
            word_cnt   <= '0;
          end else if (wd_expire) begin
            state      <= IDLE;
            SECTOR_REQ <= 1'b0;
            TIMEOUT    <= 1'b1;
          end else if (!ENABLE) begin
            state      <= IDLE;
            SECTOR_REQ <= 1'b0;
          end
        end
        STREAM: begin
          if (pad_pending) begin
            // emit the zero pad, then leave once its strobe has gone out
            if (WRITE) begin
              pad_pending <= 1'b0;
              state       <= IDLE;
            end else begin
              WRITE <= 1'b1;
              DOUT  <= '0;
            end
          end else if (accept) begin
            WRITE    <= 1'b1;
            DOUT     <= host_word;
            word_cnt <= word_cnt + 1'b1;
          end else if (WRITE && word_cnt == LAST_WORD) begin
            state        <= DONE;
            hold_cnt     <= '0;
            SECTOR_COUNT <= SECTOR_COUNT + 16'd1;
          end else if (wd_expire) begin
            // an odd word count leaves a dangling left sample; pad it to keep L/R pairing
            TIMEOUT <= 1'b1;
            if (word_cnt[0])
              pad_pending <= 1'b1;
            else
              state <= IDLE;
          end
        end
        DONE: begin
          if (hold_cnt == HOLD_LAST)
            state <= IDLE;
          else
            hold_cnt <= hold_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdda_feed.sv
// tb/tb_cdda_feed.sv - directed table and sequence bench for cdda_feed
module tb_cdda_feed;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ENABLE = 1'b0;
  logic        WRITE_REQ = 1'b0;
  logic        SECTOR_ACK = 1'b0;
  logic        HOST_VALID = 1'b0;
  logic [15:0] HOST_DATA = 16'h0000;
  logic        WRITE;
  logic [15:0] DOUT;
  logic        SECTOR_REQ;
  logic        HOST_READY;
  logic        TIMEOUT;
  logic [15:0] SECTOR_COUNT;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int dbl = 0;
  logic prev_wr = 1'b0;
  logic [15:0] wr_q[$];
  int          wr_cyc[$];

  typedef struct {
    logic en;
    logic wr;
    logic ack;
    logic valid;
    logic x_sreq;
    logic x_rdy;
    logic x_write;
    logic x_to;
  } vec_t;

  cdda_feed #(
    .SECTOR_WORDS(1176),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .ENABLE      (ENABLE),
    .WRITE_REQ   (WRITE_REQ),
    .WRITE       (WRITE),
    .DOUT        (DOUT),
    .SECTOR_REQ  (SECTOR_REQ),
    .SECTOR_ACK  (SECTOR_ACK),
    .HOST_VALID  (HOST_VALID),
    .HOST_DATA   (HOST_DATA),
    .HOST_READY  (HOST_READY),
    .TIMEOUT     (TIMEOUT),
    .SECTOR_COUNT(SECTOR_COUNT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  // record every strobe and flag back-to-back strobes
  always @(negedge CLK) begin
    if (WRITE) begin
      wr_q.push_back(DOUT);
      wr_cyc.push_back(cyc);
      if (prev_wr) dbl++;
    end
    prev_wr = WRITE;
  end

  function automatic logic [15:0] word_of(input int i);
    return 16'h1234 + 16'(i) * 16'h0107;
  endfunction

  function automatic logic [15:0] exp_dout(input logic [15:0] w);
`ifdef CDDA_FEED_BYTESWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic clear_log();
    wr_q.delete();
    wr_cyc.delete();
    dbl = 0;
  endtask

  task automatic start_sector(input string tag);
    int n;
    n = 0;
    ENABLE = 1'b1;
    WRITE_REQ = 1'b1;
    while (!SECTOR_REQ && n < 50) begin
      tick();
      n++;
    end
    chk({tag, " sector_req"}, {31'd0, SECTOR_REQ}, 32'd1);
    SECTOR_ACK = 1'b1;
    tick();
    SECTOR_ACK = 1'b0;
  endtask

  task automatic stream(input string tag, input int nwords, input int gap_max,
                        input int drop_at, output int last_acc);
    int i;
    int gap;
    int budget;
    i = 0;
    gap = 0;
    budget = 0;
    last_acc = -1;
    while (i < nwords && budget < 40000) begin
      if (i == drop_at) ENABLE = 1'b0;
      if (gap > 0) begin
        HOST_VALID = 1'b0;
        gap--;
      end else begin
        HOST_VALID = 1'b1;
        HOST_DATA = word_of(i);
        if (HOST_READY) begin
          last_acc = cyc;
          i++;
          if (gap_max > 0) gap = $urandom_range(0, gap_max);
        end
      end
      tick();
      budget++;
    end
    HOST_VALID = 1'b0;
    chk({tag, " accepted"}, i, nwords);
  endtask

  task automatic check_data(input string tag, input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < wr_q.size() && k < n; k++)
      if (wr_q[k] !== exp_dout(word_of(k))) bad++;
    chk({tag, " data"}, bad, 0);
  endtask

  initial begin
    vec_t tbl[9];
    int   acc;
    int   bad;

    // inputs applied for one cycle, outputs expected in the following cycle
    tbl = '{
      '{1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0}
    };

    RESET = 1'b1;
    repeat (2) tick();
    chk("reset WRITE", {31'd0, WRITE}, 32'd0);
    chk("reset DOUT", {16'd0, DOUT}, 32'd0);
    chk("reset SECTOR_REQ", {31'd0, SECTOR_REQ}, 32'd0);
    chk("reset HOST_READY", {31'd0, HOST_READY}, 32'd0);
    chk("reset TIMEOUT", {31'd0, TIMEOUT}, 32'd0);
    chk("reset SECTOR_COUNT", {16'd0, SECTOR_COUNT}, 32'd0);
    RESET = 1'b0;
    tick();

    for (int v = 0; v < 9; v++) begin
      ENABLE = tbl[v].en;
      WRITE_REQ = tbl[v].wr;
      SECTOR_ACK = tbl[v].ack;
      HOST_VALID = tbl[v].valid;
      HOST_DATA = 16'hDEAD;
      tick();
      chk($sformatf("vec%0d SECTOR_REQ", v), {31'd0, SECTOR_REQ}, {31'd0, tbl[v].x_sreq});
      chk($sformatf("vec%0d HOST_READY", v), {31'd0, HOST_READY}, {31'd0, tbl[v].x_rdy});
      chk($sformatf("vec%0d WRITE", v), {31'd0, WRITE}, {31'd0, tbl[v].x_write});
      chk($sformatf("vec%0d TIMEOUT", v), {31'd0, TIMEOUT}, {31'd0, tbl[v].x_to});
    end
    SECTOR_ACK = 1'b0;
    HOST_VALID = 1'b0;

    // ENABLE falls at word 300 of a sector already in progress
    clear_log();
    stream("drop", 1176, 0, 300, acc);
    repeat (8) tick();
    chk("drop SECTOR_COUNT", {16'd0, SECTOR_COUNT}, 32'd1);
    chk("drop writes", wr_q.size(), 1176);
    check_data("drop", 1176);
    chk("drop no re-request", {31'd0, SECTOR_REQ}, 32'd0);

    // full-rate sector and re-request timing
    clear_log();
    start_sector("full");
    stream("full", 1176, 0, -1, acc);
    while (cyc < acc + 6) tick();
    chk("full SECTOR_REQ at t+6", {31'd0, SECTOR_REQ}, 32'd0);
    tick();
    chk("full SECTOR_REQ at t+7", {31'd0, SECTOR_REQ}, 32'd1);
    ENABLE = 1'b0;
    tick();
    chk("req abort SECTOR_REQ", {31'd0, SECTOR_REQ}, 32'd0);
    chk("full SECTOR_COUNT", {16'd0, SECTOR_COUNT}, 32'd2);
    chk("full writes", wr_q.size(), 1176);
    chk("full first word", {16'd0, (wr_q.size() > 0) ? wr_q[0] : 16'hFFFF},
        {16'd0, exp_dout(16'h1234)});
    check_data("full", 1176);
    bad = 0;
    for (int k = 1; k < wr_cyc.size(); k++)
      if (wr_cyc[k] - wr_cyc[k-1] != 2) bad++;
    chk("full spacing", bad, 0);
    chk("full back-to-back", dbl, 0);

    // host stalls of 0..20 cycles between words
    clear_log();
    start_sector("gap");
    WRITE_REQ = 1'b0;
    stream("gap", 1176, 20, -1, acc);
    repeat (8) tick();
    chk("gap SECTOR_COUNT", {16'd0, SECTOR_COUNT}, 32'd3);
    chk("gap writes", wr_q.size(), 1176);
    check_data("gap", 1176);
    chk("gap back-to-back", dbl, 0);

    // host stops after 5 words: timeout with pad word
    clear_log();
    start_sector("to5");
    stream("to5", 5, 0, -1, acc);
    while (cyc < acc + 100) tick();
    chk("to5 TIMEOUT before", {31'd0, TIMEOUT}, 32'd0);
    tick();
    chk("to5 TIMEOUT pulse", {31'd0, TIMEOUT}, 32'd1);
    chk("to5 WRITE with pulse", {31'd0, WRITE}, 32'd0);
    tick();
    chk("to5 TIMEOUT width", {31'd0, TIMEOUT}, 32'd0);
    chk("to5 pad WRITE", {31'd0, WRITE}, 32'd1);
    chk("to5 pad DOUT", {16'd0, DOUT}, 32'd0);
    tick();
    chk("to5 idle SECTOR_REQ", {31'd0, SECTOR_REQ}, 32'd0);
    tick();
    chk("to5 re-request", {31'd0, SECTOR_REQ}, 32'd1);
    ENABLE = 1'b0;
    tick();
    chk("to5 writes", wr_q.size(), 6);
    check_data("to5", 5);
    chk("to5 SECTOR_COUNT", {16'd0, SECTOR_COUNT}, 32'd3);

    // host stops after 6 words: timeout, no pad
    clear_log();
    start_sector("to6");
    stream("to6", 6, 0, -1, acc);
    while (cyc < acc + 101) tick();
    chk("to6 TIMEOUT pulse", {31'd0, TIMEOUT}, 32'd1);
    chk("to6 SECTOR_REQ in idle", {31'd0, SECTOR_REQ}, 32'd0);
    tick();
    chk("to6 re-request", {31'd0, SECTOR_REQ}, 32'd1);
    chk("to6 no pad", {31'd0, WRITE}, 32'd0);
    ENABLE = 1'b0;
    repeat (3) tick();
    chk("to6 writes", wr_q.size(), 6);
    chk("to6 SECTOR_COUNT", {16'd0, SECTOR_COUNT}, 32'd3);

    // asynchronous reset while a word strobe is out
    clear_log();
    start_sector("rst");
    stream("rst", 10, 0, -1, acc);
    chk("rst WRITE before", {31'd0, WRITE}, 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("rst WRITE", {31'd0, WRITE}, 32'd0);
    chk("rst DOUT", {16'd0, DOUT}, 32'd0);
    chk("rst SECTOR_REQ", {31'd0, SECTOR_REQ}, 32'd0);
    chk("rst HOST_READY", {31'd0, HOST_READY}, 32'd0);
    chk("rst TIMEOUT", {31'd0, TIMEOUT}, 32'd0);
    chk("rst SECTOR_COUNT", {16'd0, SECTOR_COUNT}, 32'd0);
    tick();
    RESET = 1'b0;
    ENABLE = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
